// File: rtl/char_seq_pkg.sv
// Shared types and constants for the character sequencer.
// State enum, NUL code, default message and index width.
package char_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    HOLD
  } state_e;

  localparam int IDX_W   = 4;
  localparam int MSG_MAX = 16;

  localparam logic [6:0] CHAR_NUL = 7'h00;

  // Entry 0 is the rightmost element.
  localparam logic [MSG_MAX-1:0][6:0] DEFAULT_MSG = {
    {13{CHAR_NUL}},
    7'h33,
    7'h32,
    7'h31
  };

endpackage

// File: rtl/char_seq_buffer.sv
// Message register file: sync write, two comb read ports, entry 0 tap.
// Ports: clk, reset, we_i/wa_i/wd_i write, ra_i/ra_o, rb_i/rb_o, r0_o.
module char_seq_buffer
  import char_seq_pkg::*;
#(
  parameter int MSG_LEN = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wa_i,
  input  logic [6:0]       wd_i,
  input  logic [IDX_W-1:0] ra_i,
  output logic [6:0]       ra_o,
  input  logic [IDX_W-1:0] rb_i,
  output logic [6:0]       rb_o,
  output logic [6:0]       r0_o
);

  logic [MSG_LEN-1:0][6:0] mem_q;

  // Addresses at or past MSG_LEN match no entry and are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        mem_q[i] <= DEFAULT_MSG[i];
      end
    end else if (we_i) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        if (wa_i == IDX_W'(i)) begin
          mem_q[i] <= wd_i;
        end
      end
    end
  end

  // Out-of-range reads return NUL.
  always_comb begin
    ra_o = CHAR_NUL;
    rb_o = CHAR_NUL;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (ra_i == IDX_W'(i)) begin
        ra_o = mem_q[i];
      end
      if (rb_i == IDX_W'(i)) begin
        rb_o = mem_q[i];
      end
    end
  end

  assign r0_o = mem_q[0];

endmodule

// File: rtl/char_sequencer.sv
// Plays a message buffer out on the charAvailable/charOut handshake.
// Ports: clk, reset, enable, tick, start, stop, loop, animBusy, wr*, char*, busy, done, index.
module char_sequencer
  import char_seq_pkg::*;
#(
  parameter int MSG_LEN    = 8,
  parameter int HOLD_TICKS = 30,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  input  logic       animBusy,
  input  logic       wrEn,
  input  logic [3:0] wrAddr,
  input  logic [6:0] wrData,
  output logic       charAvailable,
  output logic [6:0] charOut,
  output logic       busy,
  output logic       done,
  output logic [3:0] index
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       char_q, char_d;
  logic             avail_q, avail_d;
  logic             done_q, done_d;

  logic [IDX_W-1:0] nxt_idx;
  logic [6:0]       cur_c;
  logic [6:0]       nxt_c;
  logic [6:0]       first_c;
  logic             last;
  logic             cnt_end;
  logic             tick_cnt;

  assign nxt_idx = idx_q + 1'b1;

  char_seq_buffer #(
    .MSG_LEN(MSG_LEN)
  ) u_buf (
    .clk  (clk),
    .reset(reset),
    .we_i (wrEn),
    .wa_i (wrAddr),
    .wd_i (wrData),
    .ra_i (idx_q),
    .ra_o (cur_c),
    .rb_i (nxt_idx),
    .rb_o (nxt_c),
    .r0_o (first_c)
  );

  assign last = (idx_q == IDX_W'(MSG_LEN - 1))
              || (nxt_c == CHAR_NUL);
  assign cnt_end = (cnt_q == CNT_W'(HOLD_TICKS - 1));
  // The tick landing on the pulse cycle belongs to the previous char.
  assign tick_cnt = tick && !avail_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    avail_d = 1'b0;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (first_c != CHAR_NUL) begin
              idx_d   = '0;
              state_d = EMIT;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        EMIT: begin
          if (!animBusy) begin
            char_d  = cur_c;
            avail_d = 1'b1;
            cnt_d   = '0;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (tick_cnt) begin
            if (!cnt_end) begin
              cnt_d = cnt_q + 1'b1;
            end else if (!last) begin
              idx_d   = nxt_idx;
              state_d = EMIT;
            end else if (loop && first_c != CHAR_NUL) begin
              idx_d   = '0;
              state_d = EMIT;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Disabled: state freezes, pending strobes are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      char_q  <= CHAR_NUL;
      avail_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (enable) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      avail_q <= avail_d;
      done_q  <= done_d;
    end else begin
      avail_q <= 1'b0;
      done_q  <= 1'b0;
    end
  end

  assign charAvailable = avail_q & enable;
  assign done          = done_q & enable;
  assign charOut       = char_q;
  assign busy          = (state_q != IDLE);
  assign index         = idx_q;

endmodule

// File: tb/tb_char_sequencer.sv
// Randomized-tick directed bench for char_sequencer.
// Reference: playlist of indices plus tick/latency timing arithmetic.
module tb_char_sequencer;

  localparam int HT = 3;
  localparam int ML = 8;

  logic       clk = 1'b0;
  logic       reset, enable, tick, start, stop, loop, animBusy;
  logic       wrEn;
  logic [3:0] wrAddr;
  logic [6:0] wrData;
  logic       charAvailable;
  logic [6:0] charOut;
  logic       busy, done;
  logic [3:0] index;

  char_sequencer #(
    .MSG_LEN   (ML),
    .HOLD_TICKS(HT),
    .CNT_W     (6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .tick         (tick),
    .start        (start),
    .stop         (stop),
    .loop         (loop),
    .animBusy     (animBusy),
    .wrEn         (wrEn),
    .wrAddr       (wrAddr),
    .wrData       (wrData),
    .charAvailable(charAvailable),
    .charOut      (charOut),
    .busy         (busy),
    .done         (done),
    .index        (index)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gap = 0;
  bit tick_on = 0;

  int npulse = 0;
  int ndone = 0;
  int last_pulse_cyc = -1;
  int first_pulse_cyc = -1;
  int last_idx = -1;
  bit saw_pulse, saw_done;

  logic [6:0] mbuf [ML];
  int         plq [$];
  bit         m_valid = 0;
  bit         m_play;
  int         m_emit_at, m_hold_from, m_left;
  int         m_pulse, m_done, m_idx;
  logic [6:0] m_char;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_default();
    for (int i = 0; i < ML; i++) mbuf[i] = 7'h00;
    mbuf[0] = 7'h31;
    mbuf[1] = 7'h32;
    mbuf[2] = 7'h33;
  endtask

  task automatic build_list();
    plq.delete();
    for (int i = 0; i < ML; i++) begin
      if (mbuf[i] == 7'h00) break;
      plq.push_back(i);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_valid   = 1;
      m_play    = 0;
      m_emit_at = -1;
      m_pulse   = -1;
      m_done    = -1;
      m_idx     = 0;
      m_char    = 7'h00;
      load_default();
      plq.delete();
      return;
    end
    if (enable) begin
      if (stop) begin
        m_play    = 0;
        m_emit_at = -1;
      end else if (!m_play) begin
        if (start) begin
          build_list();
          if (plq.size() > 0) begin
            m_play    = 1;
            m_emit_at = cyc + 1;
          end else begin
            m_done = cyc + 1;
          end
        end
      end else if (m_emit_at >= 0) begin
        if (cyc >= m_emit_at && !animBusy) begin
          m_idx       = plq[0];
          m_char      = mbuf[m_idx];
          m_pulse     = cyc + 1;
          m_hold_from = cyc + 2;
          m_left      = HT;
          m_emit_at   = -1;
        end
      end else if (tick && cyc >= m_hold_from) begin
        m_left--;
        if (m_left == 0) begin
          void'(plq.pop_front());
          if (plq.size() == 0 && loop) build_list();
          if (plq.size() > 0) begin
            m_emit_at = cyc + 1;
          end else begin
            m_play = 0;
            m_done = cyc + 1;
          end
        end
      end
    end
    if (wrEn && wrAddr < 4'd8) mbuf[int'(wrAddr)] = wrData;
  endtask

  task automatic observe();
    saw_pulse = charAvailable;
    saw_done  = done;
    if (charAvailable) begin
      npulse++;
      last_pulse_cyc = cyc;
      last_idx = int'(index);
      if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
    end
    if (done) ndone++;
    if (m_valid) begin
      chk("avail", charAvailable, (cyc == m_pulse) && enable);
      chk("done", done, (cyc == m_done) && enable);
      chk("busy", busy, m_play);
      chk("charOut", charOut, m_char);
      if (cyc == m_pulse) chk("index", index, m_idx);
    end
    model_edge();
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
    if (tick_on && gap == 0) begin
      tick = 1'b1;
      gap  = $urandom_range(3, 1);
    end else begin
      tick = 1'b0;
      if (gap > 0) gap--;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [6:0] d);
    wrEn = 1'b1; wrAddr = a; wrData = d;
    step();
    wrEn = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask

  task automatic wait_done(input string tag, input int lim);
    bit f = 0;
    for (int i = 0; i < lim && !f; i++) begin
      step();
      if (saw_done) f = 1;
    end
    chk(tag, f, 1);
  endtask

  task automatic wait_idx(input string tag, input int idx, input int lim);
    bit f = 0;
    for (int i = 0; i < lim && !f; i++) begin
      step();
      if (saw_pulse && last_idx == idx) f = 1;
    end
    chk(tag, f, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int sc, n0, d0, f;
    bit got;
    reset = 1; enable = 1; tick = 0; start = 0; stop = 0;
    loop = 0; animBusy = 0; wrEn = 0; wrAddr = 0; wrData = 0;
    repeat (3) step();
    reset = 0;
    step();
    chk("rst_charOut", charOut, 7'h00);
    chk("rst_index", index, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_avail", charAvailable, 1'b0);
    tick_on = 1;
    repeat (4) step();

    // default message, single pass
    n0 = npulse; d0 = ndone; first_pulse_cyc = -1;
    sc = cyc;
    kick();
    wait_done("s1_done_seen", 300);
    chk("s1_first_lat", first_pulse_cyc, sc + 2);
    chk("s1_pulses", npulse - n0, 3);
    chk("s1_dones", ndone - d0, 1);
    step();
    chk("s1_busy_after", busy, 1'b0);
    chk("s1_last_char", charOut, 7'h33);

    // full buffer, looping
    for (int i = 3; i < ML; i++)
      wr(4'(i), 7'($urandom_range(126, 65)));
    loop = 1;
    n0 = npulse; d0 = ndone;
    kick();
    got = 0;
    for (int i = 0; i < 800 && !got; i++) begin
      step();
      if (npulse - n0 >= 10) got = 1;
    end
    chk("s2_ten_pulses", got, 1);
    chk("s2_wrap_idx", last_idx, 1);
    chk("s2_no_done", ndone - d0, 0);
    halt();

    // animBusy stall across an emit
    loop = 0;
    kick();
    wait_idx("s3_first", 0, 60);
    animBusy = 1;
    n0 = npulse;
    repeat (30) step();
    chk("s3_stall_quiet", npulse - n0, 0);
    animBusy = 0;
    f = cyc;
    step();
    step();
    chk("s3_stall_lat", last_pulse_cyc, f + 1);
    chk("s3_stall_idx", last_idx, 1);
    wait_done("s3_done_seen", 400);

    // stop mid-hold at index 2
    kick();
    wait_idx("s4_at2", 2, 200);
    step();
    stop = 1;
    step();
    stop = 0;
    d0 = ndone;
    repeat (5) step();
    chk("s4_busy", busy, 1'b0);
    chk("s4_char", charOut, 7'h33);
    chk("s4_no_done", ndone - d0, 0);
    kick();
    wait_idx("s4_restart0", 0, 60);
    halt();

    // write to held index, then second pass
    loop = 1;
    kick();
    wait_idx("s5_at1", 1, 100);
    wr(4'd1, 7'h55);
    step();
    chk("s5_hold_char", charOut, 7'h32);
    wr(4'd9, 7'($urandom_range(126, 1)));
    wait_idx("s5_wrap7", 7, 400);
    wait_idx("s5_again1", 1, 100);
    chk("s5_new_char", charOut, 7'h55);
    halt();

    // enable low during hold
    loop = 0;
    kick();
    wait_idx("s6_at0", 0, 60);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (m_left == HT - 1) got = 1;
    end
    chk("s6_one_tick", got, 1);
    enable = 0;
    n0 = npulse;
    repeat (44) step();
    chk("s6_frozen_pulses", npulse - n0, 0);
    chk("s6_frozen_busy", busy, 1'b1);
    chk("s6_frozen_idx", index, 4'd0);
    enable = 1;
    wait_idx("s6_resume1", 1, 60);
    wait_done("s6_done_seen", 400);

    // empty message
    wr(4'd0, 7'h00);
    n0 = npulse; d0 = ndone;
    kick();
    repeat (6) step();
    chk("s7_done_only", ndone - d0, 1);
    chk("s7_no_pulse", npulse - n0, 0);
    chk("s7_idle", busy, 1'b0);

    // reset on the emit cycle
    reset = 1;
    step();
    reset = 0;
    step();
    loop = 1;
    n0 = npulse;
    kick();
    reset = 1;
    step();
    reset = 0;
    step();
    chk("s8_no_pulse", npulse - n0, 0);
    chk("s8_char", charOut, 7'h00);
    chk("s8_busy", busy, 1'b0);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_sequencer.md
Name: char_sequencer

Overview:
- Producer for the character handshake (charAvailable strobe plus 7-bit char code) consumed by the segment animator.
- Holds a small writable message buffer and plays it back one character at a time.
- Each character is held for a programmable number of 60 Hz ticks; playback either stops at the end or loops.
- Sits between the top-level input pins and the animator. The top level selects whether the animator is fed by the pins or by this block.

Parameters:
- MSG_LEN, 8, number of message buffer entries (2..16)
- HOLD_TICKS, 30, clk60 ticks each character is held before the next is issued (>=1)
- CNT_W, 6, width of the hold counter (must satisfy 2^CNT_W > HOLD_TICKS)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  design enable; low freezes all state
- tick  in  1  one-clk-wide pulse at 60 Hz, from the clock divider
- start  in  1  begin playback from index 0 (sampled in IDLE only)
- stop  in  1  abort playback; return to IDLE
- loop  in  1  1 = wrap to index 0 after the last character
- animBusy  in  1  animator is mid-animation; do not issue a character
- wrEn  in  1  message buffer write strobe
- wrAddr  in  4  write index (values >= MSG_LEN are ignored)
- wrData  in  7  character code to write
- charAvailable  out  1  one-clk pulse; charOut is valid in the same cycle
- charOut  out  7  current character code; held stable between pulses
- busy  out  1  high in every state except IDLE
- done  out  1  one-clk pulse when a non-looping playback ends
- index  out  4  buffer index of the current character

Behaviour:
- Reset:
  - state=IDLE.
  - charAvailable, busy, done = 0; charOut = 7'h00; index = 0; holdCnt = 0.
  - Buffer loaded with DEFAULT_MSG from the package.
- enable=0:
  - All registers hold; tick, start and stop are ignored; charAvailable and done are forced to 0.
  - Buffer writes still occur.
- States: IDLE, EMIT, HOLD.
- IDLE:
  - start=1 with buf[0]!=0: index<=0, go to EMIT.
  - start=1 with buf[0]==0: done pulses next cycle; stay in IDLE; no charAvailable.
- EMIT:
  - animBusy=1: stay in EMIT; nothing is issued.
  - animBusy=0: register charOut<=buf[index] and charAvailable<=1 (so both are visible the following cycle); holdCnt<=0; go to HOLD.
- HOLD:
  - Each tick increments holdCnt.
  - A tick in the same cycle charAvailable is high is not counted.
  - On the tick where holdCnt==HOLD_TICKS-1, the message ends if index==MSG_LEN-1 or buf[index+1]==7'h00:
    - loop=1: index<=0, go to EMIT (buf[0]==0 here ends as non-looping).
    - loop=0: done pulses, go to IDLE.
  - Otherwise: index<=index+1, go to EMIT.
- Latency:
  - start sampled at edge N → EMIT during N+1 → charAvailable high during cycle N+2 (if animBusy=0).
  - Character period = HOLD_TICKS ticks, plus any animBusy stall, plus 1 clk.
- stop:
  - Has priority over all transitions: next state is IDLE; busy drops; no done pulse; charOut keeps its last value.
  - stop and start in the same IDLE cycle: stop wins.
- start while busy: ignored.
- Writes:
  - Take effect at the clock edge.
  - Read-before-write when the EMIT read and a write hit the same address: the old data is emitted.
  - A write to the currently held index does not change charOut until that index is re-emitted.
- A mid-operation reset overrides everything, including a pending charAvailable.
- charOut changes only in the cycle charAvailable is high (and at reset).

Decomposition:
- Package char_seq_pkg:
  - State enum (IDLE, EMIT, HOLD).
  - CHAR_NUL = 7'h00.
  - DEFAULT_MSG constant array (MSG_LEN x 7).
  - Index width localparam.
- One natural sub-module, char_seq_buffer:
  - MSG_LEN x 7 register file.
  - Synchronous write, combinational read.
  - Reset load of DEFAULT_MSG.
- The FSM and hold counter stay in char_sequencer.

Test Plan:
- Reset, then start with DEFAULT_MSG = {7'h31,7'h32,7'h33,0,…}, loop=0, HOLD_TICKS=3 → exactly 3 charAvailable pulses carrying 31, 32, 33, each 3 ticks apart. The first pulse is 2 clk after start; done pulses once 3 ticks after the third character; busy then goes to 0.
- loop=1, full 8-entry buffer with no NUL → 8 pulses with index 0..7, then index wraps to 0 and playback continues; done never pulses.
- animBusy held high for 20 clk at an EMIT → no pulse during the stall; the pulse appears 1 clk after animBusy falls, with the correct char; hold counting starts afterwards.
- stop asserted mid-HOLD at index 2 → IDLE next cycle, busy=0, no done, charOut holds 33. A later start restarts at index 0.
- Write wrAddr=1 with wrData=7'h55 during HOLD on index 1 → charOut stays 32 for that character. On a looped second pass, index 1 emits 55. Writes to wrAddr=9 do not change any buffer entry.
- enable=0 for 10 ticks during HOLD → holdCnt and state frozen, no pulses. After enable returns, the remaining ticks complete the hold. Start with buf[0]=0 → done pulse only, no charAvailable.
